// File: rtl/imem_loader_if.sv
// Byte-stream intake and instruction-memory write port of the boot loader.
// The loader sits on the slave side; the byte source / memory model takes the master side.
interface imem_loader_if #(
    parameter int ADDR_W = 10
);
    logic [7:0]        in_data;
    logic              in_valid;
    logic              in_ready;
    logic              imem_we;
    logic [ADDR_W-1:0] imem_addr;
    logic [31:0]       imem_wdata;

    modport slave (
        input  in_data, in_valid,
        output in_ready, imem_we, imem_addr, imem_wdata
    );

    modport master (
        output in_data, in_valid,
        input  in_ready, imem_we, imem_addr, imem_wdata
    );
endinterface

// File: rtl/imem_loader.sv
// Boot-time loader: assembles little-endian words from a length-prefixed byte
// stream, writes them to instruction memory and releases the core on a good checksum.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// S_IDLE   | no session since reset, core held in reset
// S_LEN_LO | waiting for word-count low byte
// S_LEN_HI | waiting for word-count high byte, range check on N
// S_DATA   | receiving data bytes, one write per completed word
// S_CHECK  | waiting for checksum byte
// S_DONE   | image verified, core released
// S_ERR    | oversize length or checksum mismatch, core held in reset
module imem_loader #(
    parameter int ADDR_W = 10
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    imem_loader_if.slave  bus,
    output logic          core_rst_n,
    output logic          busy,
    output logic          done,
    output logic          err
);

    typedef enum logic [2:0] {
        S_IDLE, S_LEN_LO, S_LEN_HI, S_DATA, S_CHECK, S_DONE, S_ERR
    } state_t;

    localparam logic [16:0] CAP = 17'(1) << ADDR_W;

    state_t            state, state_nxt;
    logic              ready;
    logic              accept;
    logic              start_ok;
    logic [7:0]        len_lo;
    logic [16:0]       n_full;
    logic [ADDR_W:0]   nwords;
    logic [ADDR_W:0]   wcnt;
    logic [ADDR_W:0]   word_inc;
    logic [1:0]        bcnt;
    logic [23:0]       word_buf;
    logic [7:0]        csum;

    assign accept   = bus.in_valid && ready;
    assign start_ok = start && (state == S_IDLE || state == S_DONE || state == S_ERR);
    assign n_full   = {1'b0, bus.in_data, len_lo};
    assign word_inc = wcnt + {{ADDR_W{1'b0}}, 1'b1};
    assign bus.in_ready = ready;

    always_ff @(posedge clk) begin
        if (!rst) state <= S_IDLE;
        else      state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE, S_DONE, S_ERR: if (start) state_nxt = S_LEN_LO;
            S_LEN_LO: if (accept) state_nxt = S_LEN_HI;
            S_LEN_HI: begin
                if (accept) begin
                    if (n_full > CAP)       state_nxt = S_ERR;
                    else if (n_full == '0)  state_nxt = S_CHECK;
                    else                    state_nxt = S_DATA;
                end
            end
            S_DATA: if (accept && bcnt == 2'd3 && word_inc == nwords) state_nxt = S_CHECK;
            S_CHECK: if (accept) state_nxt = (bus.in_data == csum) ? S_DONE : S_ERR;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        ready      = 1'b0;
        busy       = 1'b0;
        done       = 1'b0;
        err        = 1'b0;
        core_rst_n = 1'b0;
        case (state)
            S_LEN_LO, S_LEN_HI, S_DATA, S_CHECK: begin
                ready = 1'b1;
                busy  = 1'b1;
            end
            S_DONE: begin
                done       = 1'b1;
                core_rst_n = 1'b1;
            end
            S_ERR:   err = 1'b1;
            default: ;
        endcase
    end

    // Byte lanes 0..2 are buffered; lane 3 goes straight into the write word.
    always_ff @(posedge clk) begin
        if (!rst) begin
            bus.imem_we    <= 1'b0;
            bus.imem_addr  <= '0;
            bus.imem_wdata <= '0;
            len_lo         <= '0;
            nwords         <= '0;
            wcnt           <= '0;
            bcnt           <= '0;
            word_buf       <= '0;
            csum           <= '0;
        end else begin
            bus.imem_we <= 1'b0;
            if (start_ok) begin
                csum <= '0;
                bcnt <= '0;
                wcnt <= '0;
            end else if (accept) begin
                case (state)
                    S_LEN_LO: begin
                        len_lo <= bus.in_data;
                        csum   <= csum ^ bus.in_data;
                    end
                    S_LEN_HI: begin
                        nwords <= n_full[ADDR_W:0];
                        csum   <= csum ^ bus.in_data;
                    end
                    S_DATA: begin
                        csum <= csum ^ bus.in_data;
                        bcnt <= bcnt + 2'd1;
                        case (bcnt)
                            2'd0: word_buf[7:0]   <= bus.in_data;
                            2'd1: word_buf[15:8]  <= bus.in_data;
                            2'd2: word_buf[23:16] <= bus.in_data;
                            default: begin
                                bus.imem_we    <= 1'b1;
                                bus.imem_addr  <= wcnt[ADDR_W-1:0];
                                bus.imem_wdata <= {bus.in_data, word_buf};
                                wcnt           <= word_inc;
                            end
                        endcase
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader: scoreboarded memory writes plus
// per-scenario status checks on the loader's handshake and core-reset outputs.
module tb_imem_loader;
    localparam int AW = 4;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic start = 1'b0;
    logic core_rst_n, busy, done, err;

    imem_loader_if #(.ADDR_W(AW)) bus ();

    imem_loader #(.ADDR_W(AW)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .bus        (bus),
        .core_rst_n (core_rst_n),
        .busy       (busy),
        .done       (done),
        .err        (err)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    logic [AW+31:0] exp_q[$];
    logic [AW+31:0] mon_e;
    logic [7:0]     stream[$];
    logic [31:0]    words[$];

    // Every write strobe is matched against the next expected {addr, data}.
    always @(negedge clk) begin
        if (bus.imem_we === 1'b1) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_write addr=%0d data=%h", bus.imem_addr, bus.imem_wdata);
            end else begin
                mon_e = exp_q.pop_front();
                if ({bus.imem_addr, bus.imem_wdata} !== mon_e) begin
                    errors++;
                    $display("FAIL write_value got addr=%0d data=%h expected addr=%0d data=%h",
                             bus.imem_addr, bus.imem_wdata, mon_e[AW+31:32], mon_e[31:0]);
                end
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1);
    end

    task automatic build_stream(input logic [15:0] n, input bit bad);
        logic [7:0] c;
        stream.delete();
        stream.push_back(n[7:0]);
        stream.push_back(n[15:8]);
        foreach (words[i]) begin
            for (int b = 0; b < 4; b++) begin
                logic [31:0] w;
                w = words[i] >> (8 * b);
                stream.push_back(w[7:0]);
            end
        end
        c = 8'h00;
        foreach (stream[i]) c = c ^ stream[i];
        if (bad) c = c ^ 8'h01;
        stream.push_back(c);
    endtask

    task automatic fixed_words();
        words.delete();
        words.push_back(32'h11223344);
        words.push_back(32'hAABBCCDD);
    endtask

    task automatic random_words(input int n);
        words.delete();
        for (int i = 0; i < n; i++) words.push_back($urandom);
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b, output bit ok);
        int t;
        bus.in_data  = b;
        bus.in_valid = 1'b1;
        t = 0;
        @(negedge clk);
        while (bus.in_ready !== 1'b1 && t < 20) begin
            @(negedge clk);
            t++;
        end
        ok = (bus.in_ready === 1'b1);
        if (!ok) begin
            checks++;
            errors++;
            $display("FAIL handshake_timeout in_ready=%b expected 1 within 20 cycles", bus.in_ready);
            bus.in_valid = 1'b0;
        end else begin
            @(posedge clk); #1;
            bus.in_valid = 1'b0;
        end
    endtask

    // Sends stream[from..to-1]; pushes expected writes as each word's last byte goes out.
    task automatic send_stream(input int from, input int to, input bit gap, input int start_at);
        int n;
        int w;
        bit ok;
        n = {stream[1], stream[0]};
        for (int i = from; i < to; i++) begin
            if (i == start_at) pulse_start();
            if (i >= 2 && i < 2 + 4 * n && ((i - 2) % 4) == 3) begin
                w = (i - 2) / 4;
                exp_q.push_back({w[AW-1:0], words[w]});
            end
            send_byte(stream[i], ok);
            if (!ok) break;
            if (gap) begin
                @(posedge clk); #1;
            end
        end
    endtask

    task automatic check_drained(input string name);
        @(negedge clk); #1;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL %s_writes_missing pending=%0d expected 0", name, exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic test_reset();
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({bus.in_ready, bus.imem_we, core_rst_n, busy, done, err} !== 6'b0) begin
            errors++;
            $display("FAIL reset_status got rdy/we/crn/busy/done/err=%b expected 000000",
                     {bus.in_ready, bus.imem_we, core_rst_n, busy, done, err});
        end
        checks++;
        if (bus.imem_addr !== '0 || bus.imem_wdata !== 32'h0) begin
            errors++;
            $display("FAIL reset_bus got addr=%h data=%h expected 0/0", bus.imem_addr, bus.imem_wdata);
        end
        rst = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_basic();
        fixed_words();
        build_stream(16'd2, 1'b0);
        pulse_start();
        checks++;
        if ({busy, bus.in_ready, done, core_rst_n} !== 4'b1100) begin
            errors++;
            $display("FAIL basic_start got busy/rdy/done/crn=%b expected 1100",
                     {busy, bus.in_ready, done, core_rst_n});
        end
        send_stream(0, 6, 1'b0, -1);
        checks++;
        if (bus.imem_we !== 1'b1 || bus.imem_addr !== 4'd0 || bus.imem_wdata !== 32'h11223344) begin
            errors++;
            $display("FAIL basic_write_timing got we=%b addr=%0d data=%h expected 1/0/11223344",
                     bus.imem_we, bus.imem_addr, bus.imem_wdata);
        end
        send_stream(6, stream.size(), 1'b0, -1);
        checks++;
        if ({busy, done, err, core_rst_n} !== 4'b0101) begin
            errors++;
            $display("FAIL basic_done got busy/done/err/crn=%b expected 0101",
                     {busy, done, err, core_rst_n});
        end
        check_drained("basic");
    endtask

    task automatic test_bad_chk();
        fixed_words();
        build_stream(16'd2, 1'b1);
        pulse_start();
        send_stream(0, stream.size(), 1'b0, -1);
        checks++;
        if ({busy, done, err, core_rst_n} !== 4'b0010) begin
            errors++;
            $display("FAIL badchk_err got busy/done/err/crn=%b expected 0010",
                     {busy, done, err, core_rst_n});
        end
        check_drained("badchk");
        pulse_start();
        checks++;
        if ({busy, err} !== 2'b10) begin
            errors++;
            $display("FAIL badchk_restart got busy/err=%b expected 10", {busy, err});
        end
        // Continue the session just opened with an empty image.
        words.delete();
        build_stream(16'd0, 1'b0);
        send_stream(0, stream.size(), 1'b0, -1);
        checks++;
        if ({done, err, core_rst_n} !== 3'b101) begin
            errors++;
            $display("FAIL zero_done got done/err/crn=%b expected 101", {done, err, core_rst_n});
        end
        check_drained("zero");
    endtask

    task automatic test_zero_bad();
        words.delete();
        build_stream(16'd0, 1'b1);
        pulse_start();
        send_stream(0, stream.size(), 1'b0, -1);
        checks++;
        if ({done, err, core_rst_n} !== 3'b010) begin
            errors++;
            $display("FAIL zero_bad got done/err/crn=%b expected 010", {done, err, core_rst_n});
        end
    endtask

    task automatic test_oversize();
        words.delete();
        build_stream(16'd17, 1'b0);
        pulse_start();
        send_stream(0, 2, 1'b0, -1);
        checks++;
        if ({err, bus.in_ready, busy, core_rst_n} !== 4'b1000) begin
            errors++;
            $display("FAIL oversize got err/rdy/busy/crn=%b expected 1000",
                     {err, bus.in_ready, busy, core_rst_n});
        end
        repeat (4) @(posedge clk);
        check_drained("oversize");
    endtask

    task automatic test_full();
        random_words(16);
        build_stream(16'd16, 1'b0);
        pulse_start();
        send_stream(0, stream.size(), 1'b0, -1);
        checks++;
        if ({done, err, core_rst_n} !== 3'b101) begin
            errors++;
            $display("FAIL full_done got done/err/crn=%b expected 101", {done, err, core_rst_n});
        end
        check_drained("full");
    endtask

    task automatic test_gaps();
        fixed_words();
        build_stream(16'd2, 1'b0);
        pulse_start();
        send_stream(0, stream.size(), 1'b1, -1);
        checks++;
        if ({done, err, core_rst_n} !== 3'b101) begin
            errors++;
            $display("FAIL gaps_done got done/err/crn=%b expected 101", {done, err, core_rst_n});
        end
        check_drained("gaps");
    endtask

    task automatic test_reset_mid();
        fixed_words();
        build_stream(16'd2, 1'b0);
        pulse_start();
        send_stream(0, 8, 1'b0, -1);
        rst = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        checks++;
        if ({bus.in_ready, bus.imem_we, core_rst_n, busy, done, err} !== 6'b0 ||
            bus.imem_addr !== '0 || bus.imem_wdata !== 32'h0) begin
            errors++;
            $display("FAIL midreset_outputs got rdy/we/crn/busy/done/err=%b addr=%h data=%h expected zeros",
                     {bus.in_ready, bus.imem_we, core_rst_n, busy, done, err}, bus.imem_addr, bus.imem_wdata);
        end
        bus.in_data  = 8'h5A;
        bus.in_valid = 1'b1;
        repeat (8) @(posedge clk);
        #1;
        checks++;
        if (bus.in_ready !== 1'b0) begin
            errors++;
            $display("FAIL midreset_idle_ready got %b expected 0", bus.in_ready);
        end
        bus.in_valid = 1'b0;
        check_drained("midreset");
        random_words(3);
        build_stream(16'd3, 1'b0);
        pulse_start();
        send_stream(0, stream.size(), 1'b0, -1);
        checks++;
        if ({done, err, core_rst_n} !== 3'b101) begin
            errors++;
            $display("FAIL midreset_recover got done/err/crn=%b expected 101", {done, err, core_rst_n});
        end
        check_drained("recover");
    endtask

    task automatic test_start_ignored();
        fixed_words();
        build_stream(16'd2, 1'b0);
        pulse_start();
        send_stream(0, stream.size(), 1'b0, 4);
        checks++;
        if ({done, err, core_rst_n} !== 3'b101) begin
            errors++;
            $display("FAIL start_in_data got done/err/crn=%b expected 101", {done, err, core_rst_n});
        end
        check_drained("start_in_data");
    endtask

    task automatic test_back_to_back();
        pulse_start();
        checks++;
        if ({core_rst_n, done, busy} !== 3'b001) begin
            errors++;
            $display("FAIL restart_from_done got crn/done/busy=%b expected 001", {core_rst_n, done, busy});
        end
        random_words(4);
        build_stream(16'd4, 1'b0);
        send_stream(0, stream.size(), 1'b0, -1);
        checks++;
        if ({done, err, core_rst_n} !== 3'b101) begin
            errors++;
            $display("FAIL b2b_done got done/err/crn=%b expected 101", {done, err, core_rst_n});
        end
        check_drained("b2b");
    endtask

    initial begin
        bus.in_data  = 8'h00;
        bus.in_valid = 1'b0;
        test_reset();
        test_basic();
        test_bad_chk();
        test_zero_bad();
        test_oversize();
        test_full();
        test_gaps();
        test_reset_mid();
        test_start_ignored();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
